// File: rtl/operand_entry.sv
// operand_entry: keypad operand entry controller.
// Synchronises and debounces a raw key request, executes one hex-digit or
// edit/commit command per press, and loads the typed value into the A or B
// operand register with a single-cycle load strobe.
module operand_entry #(
    parameter int HOLDOFF = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_req,
    input  logic [4:0]  key_code,
    output logic [31:0] entry,
    output logic [3:0]  ndig,
    output logic        full,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic        ld_a,
    output logic        ld_b,
    output logic        err
);

    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [4:0] KEY_BS    = 5'h10;
    localparam logic [4:0] KEY_CLR   = 5'h11;
    localparam logic [4:0] KEY_COM_A = 5'h12;
    localparam logic [4:0] KEY_COM_B = 5'h13;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_REL
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            req_m, req_s;
    logic            exec;

    logic [31:0]     entry_nx, a_nx, b_nx;
    logic [3:0]      ndig_nx;
    logic            ld_a_nx, ld_b_nx, err_nx;

    // Two-stage synchroniser for the asynchronous key request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: both stages reset to 1 so a key held through reset looks
            // like an old press that must be released before the next one.
            req_m <= 1'b1;
            req_s <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make req_s take the old req_m;
            // blocking ones would collapse the two stages into one.
            req_m <= key_req;
            req_s <= req_m;
        end
    end

    // Debounce FSM state and hold-off counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_REL;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Debounce next-state logic: accept a press in IDLE, then hold off and
    // wait for release before accepting the next one.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nx = state;
        cnt_nx   = cnt;
        exec     = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    exec     = 1'b1;
                    cnt_nx   = CW'(HOLDOFF - 1);
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nx = WAIT_REL;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            WAIT_REL: begin
                if (!req_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = WAIT_REL;
        endcase
    end

    // Key action decode: compute the next entry/operand values and strobes.
    always_comb begin
        entry_nx = entry;
        ndig_nx  = ndig;
        a_nx     = A;
        b_nx     = B;
        ld_a_nx  = 1'b0;
        ld_b_nx  = 1'b0;
        err_nx   = 1'b0;
        if (exec) begin
            if (!key_code[4]) begin
                if (ndig != 4'd8) begin
                    entry_nx = {entry[27:0], key_code[3:0]};
                    ndig_nx  = ndig + 4'd1;
                end else begin
                    err_nx = 1'b1;
                end
            end else begin
                case (key_code)
                    KEY_BS: begin
                        if (ndig != 4'd0) begin
                            entry_nx = entry >> 4;
                            ndig_nx  = ndig - 4'd1;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end
                    KEY_CLR: begin
                        entry_nx = '0;
                        ndig_nx  = '0;
                    end
                    KEY_COM_A: begin
                        a_nx     = entry;
                        ld_a_nx  = 1'b1;
                        entry_nx = '0;
                        ndig_nx  = '0;
                    end
                    KEY_COM_B: begin
                        b_nx     = entry;
                        ld_b_nx  = 1'b1;
                        entry_nx = '0;
                        ndig_nx  = '0;
                    end
                    default: err_nx = 1'b1;
                endcase
            end
        end
    end

    // Registered entry, operands and strobes; strobes and operand updates
    // share an edge so a consumer sampling on ld_a/ld_b sees the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
            ndig  <= '0;
            A     <= '0;
            B     <= '0;
            ld_a  <= 1'b0;
            ld_b  <= 1'b0;
            err   <= 1'b0;
        end else begin
            entry <= entry_nx;
            ndig  <= ndig_nx;
            A     <= a_nx;
            B     <= b_nx;
            ld_a  <= ld_a_nx;
            ld_b  <= ld_b_nx;
            err   <= err_nx;
        end
    end

    // Full flag decoded from the digit count register.
    assign full = (ndig == 4'd8);

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: self-checking bench for operand_entry.
// Directed vector table, hand-written debounce/reset sequences, and random
// presses checked against a digit-queue reference model.
module tb_operand_entry;

    localparam int HOLDOFF = 16;

    logic        clk;
    logic        rst_n;
    logic        key_req;
    logic [4:0]  key_code;
    logic [31:0] entry;
    logic [3:0]  ndig;
    logic        full;
    logic [31:0] A;
    logic [31:0] B;
    logic        ld_a;
    logic        ld_b;
    logic        err;

    operand_entry #(.HOLDOFF(HOLDOFF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_req  (key_req),
        .key_code (key_code),
        .entry    (entry),
        .ndig     (ndig),
        .full     (full),
        .A        (A),
        .B        (B),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per press: key code plus the outputs expected afterwards.
    typedef struct {
        logic [4:0]  code;
        logic [31:0] entry;
        logic [3:0]  ndig;
        logic [31:0] a;
        logic [31:0] b;
        logic        ld_a;
        logic        ld_b;
        logic        err;
    } vec_t;

    // What the bench observed around one press.
    typedef struct {
        logic [31:0] pre_entry;
        logic        pre_pulse;
        logic [31:0] entry;
        logic [3:0]  ndig;
        logic        full;
        logic [31:0] a;
        logic [31:0] b;
        logic        ld_a;
        logic        ld_b;
        logic        err;
        logic        post_pulse;
    } obs_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: typed digits kept as a queue, oldest first.
    logic [3:0]  mq[$];
    logic [31:0] m_a;
    logic [31:0] m_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [4:0] code, input logic [31:0] e, input logic [3:0] n,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic la, input logic lb, input logic er);
        vec_t v;
        v.code = code; v.entry = e; v.ndig = n; v.a = a; v.b = b;
        v.ld_a = la; v.ld_b = lb; v.err = er;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] model_entry();
        logic [31:0] e = 0;
        foreach (mq[i]) e = e * 16 + 32'(mq[i]);
        return e;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_a = 0;
        m_b = 0;
    endfunction

    // Apply one key to the model and report the expected outputs.
    function automatic vec_t model_step(input logic [4:0] code);
        vec_t e;
        e.code = code; e.ld_a = 0; e.ld_b = 0; e.err = 0;
        if (code < 16) begin
            if (mq.size() < 8) mq.push_back(code[3:0]);
            else e.err = 1;
        end else if (code == 5'h10) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else e.err = 1;
        end else if (code == 5'h11) begin
            mq.delete();
        end else if (code == 5'h12) begin
            m_a = model_entry(); mq.delete(); e.ld_a = 1;
        end else if (code == 5'h13) begin
            m_b = model_entry(); mq.delete(); e.ld_b = 1;
        end else begin
            e.err = 1;
        end
        e.entry = model_entry();
        e.ndig  = 4'(mq.size());
        e.a = m_a;
        e.b = m_b;
        return e;
    endfunction

    // One full press: assert, observe latency and pulse width, release, settle.
    task automatic press(input logic [4:0] code, output obs_t o);
        key_code = code;
        key_req  = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        o.pre_entry = entry;
        o.pre_pulse = ld_a | ld_b | err;
        @(posedge clk); #1;
        o.entry = entry; o.ndig = ndig; o.full = full;
        o.a = A; o.b = B; o.ld_a = ld_a; o.ld_b = ld_b; o.err = err;
        @(posedge clk); #1;
        o.post_pulse = ld_a | ld_b | err;
        key_req = 1'b0;
        repeat (HOLDOFF + 6) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input obs_t o, input vec_t e, input logic [31:0] prev_entry);
        check({tag, " early entry"}, o.pre_entry, prev_entry);
        check({tag, " early pulse"}, 32'(o.pre_pulse), 0);
        check({tag, " entry"}, o.entry, e.entry);
        check({tag, " ndig"}, 32'(o.ndig), 32'(e.ndig));
        check({tag, " full"}, 32'(o.full), 32'(e.ndig == 4'd8));
        check({tag, " A"}, o.a, e.a);
        check({tag, " B"}, o.b, e.b);
        check({tag, " ld_a"}, 32'(o.ld_a), 32'(e.ld_a));
        check({tag, " ld_b"}, 32'(o.ld_b), 32'(e.ld_b));
        check({tag, " err"}, 32'(o.err), 32'(e.err));
        check({tag, " pulse width"}, 32'(o.post_pulse), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " entry"}, entry, 0);
        check({tag, " ndig"}, 32'(ndig), 0);
        check({tag, " full"}, 32'(full), 0);
        check({tag, " A"}, A, 0);
        check({tag, " B"}, B, 0);
        check({tag, " pulses"}, 32'({ld_a, ld_b, err}), 0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        key_req = 1'b0;
        #12;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        model_reset();
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t        o;
        vec_t        e;
        logic [31:0] prev;
        logic [4:0]  code;
        int          pulses;
        int          r;

        key_req  = 1'b0;
        key_code = 5'h00;
        rst_n    = 1'b1;
        #3;

        // Directed table from reset: code, entry, ndig, A, B, ld_a, ld_b, err.
        add(5'h01, 32'h1, 1, 0, 0, 0, 0, 0);
        add(5'h02, 32'h12, 2, 0, 0, 0, 0, 0);
        add(5'h03, 32'h123, 3, 0, 0, 0, 0, 0);
        add(5'h04, 32'h1234, 4, 0, 0, 0, 0, 0);
        add(5'h12, 32'h0, 0, 32'h1234, 0, 1, 0, 0);
        add(5'h0F, 32'hF, 1, 32'h1234, 0, 0, 0, 0);
        add(5'h0F, 32'hFF, 2, 32'h1234, 0, 0, 0, 0);
        add(5'h0F, 32'hFFF, 3, 32'h1234, 0, 0, 0, 0);
        add(5'h0F, 32'hFFFF, 4, 32'h1234, 0, 0, 0, 0);
        add(5'h0F, 32'hFFFFF, 5, 32'h1234, 0, 0, 0, 0);
        add(5'h0F, 32'hFFFFFF, 6, 32'h1234, 0, 0, 0, 0);
        add(5'h0F, 32'hFFFFFFF, 7, 32'h1234, 0, 0, 0, 0);
        add(5'h0F, 32'hFFFFFFFF, 8, 32'h1234, 0, 0, 0, 0);
        add(5'h0F, 32'hFFFFFFFF, 8, 32'h1234, 0, 0, 0, 1);
        add(5'h11, 32'h0, 0, 32'h1234, 0, 0, 0, 0);
        add(5'h11, 32'h0, 0, 32'h1234, 0, 0, 0, 0);
        add(5'h0A, 32'hA, 1, 32'h1234, 0, 0, 0, 0);
        add(5'h0B, 32'hAB, 2, 32'h1234, 0, 0, 0, 0);
        add(5'h10, 32'hA, 1, 32'h1234, 0, 0, 0, 0);
        add(5'h10, 32'h0, 0, 32'h1234, 0, 0, 0, 0);
        add(5'h10, 32'h0, 0, 32'h1234, 0, 0, 0, 1);
        add(5'h00, 32'h0, 1, 32'h1234, 0, 0, 0, 0);
        add(5'h05, 32'h5, 2, 32'h1234, 0, 0, 0, 0);
        add(5'h13, 32'h0, 0, 32'h1234, 32'h5, 0, 1, 0);
        add(5'h13, 32'h0, 0, 32'h1234, 32'h0, 0, 1, 0);
        add(5'h1F, 32'h0, 0, 32'h1234, 32'h0, 0, 0, 1);
        add(5'h07, 32'h7, 1, 32'h1234, 32'h0, 0, 0, 0);
        add(5'h15, 32'h7, 1, 32'h1234, 32'h0, 0, 0, 1);
        add(5'h12, 32'h0, 0, 32'h7, 32'h0, 1, 0, 0);

        do_reset();
        prev = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            press(vecs[i].code, o);
            compare($sformatf("vec%0d", i), o, vecs[i], prev);
            prev = vecs[i].entry;
        end

        // Bouncing key_req during hold-off executes the digit only once.
        do_reset();
        key_code = 5'h07;
        key_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bounce first action", entry, 32'h7);
        for (int i = 0; i < 10; i++) begin
            key_req = ~key_req;
            @(posedge clk);
            #1;
        end
        key_req = 1'b0;
        repeat (HOLDOFF + 10) @(posedge clk);
        #1;
        check("bounce entry", entry, 32'h7);
        check("bounce ndig", 32'(ndig), 1);

        // Reset mid-hold with the key still held: no re-execution afterwards.
        do_reset();
        key_code = 5'h03;
        key_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("hold-reset pre entry", entry, 32'h3);
        #1;
        rst_n = 1'b0;
        #10;
        check_zero("hold-reset");
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (ld_a | ld_b | err | (ndig != 0)) pulses++;
        end
        check("held key after reset activity", 32'(pulses), 0);
        check("held key after reset entry", entry, 0);
        key_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        model_reset();
        e = model_step(5'h05);
        press(5'h05, o);
        compare("after-release", o, e, 32'h0);

        // Random presses against the digit-queue model.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      code = 5'($urandom_range(0, 15));
            else if (r < 9) code = 5'($urandom_range(16, 19));
            else            code = 5'($urandom_range(20, 31));
            prev = model_entry();
            e = model_step(code);
            press(code, o);
            compare($sformatf("rand%0d code%02h", i, code), o, e, prev);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
# operand_entry

Keypad-side operand entry controller for the ALU datapath, the input counterpart of the seven-segment display scanner. It turns raw key events (hex digits plus edit/commit commands) into 32-bit operands and drives them onto the ALU A/B operand registers with single-cycle load strobes. It includes synchronisation and debounce of the raw key request. The in-progress value is exported so the display scanner can echo it while the user types.

## Interface
Parameters:
- HOLDOFF, 16: debounce hold-off in clk cycles after an accepted key (≥1).

Ports (single clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_req  in  1  raw asynchronous key-pressed level; one press = one event.
- key_code  in  5  0x00–0x0F hex digit; 0x10 backspace; 0x11 clear; 0x12 commit-A; 0x13 commit-B; other codes undefined. Stable while key_req is high.
- entry  out  32  value being typed, right-aligned hex.
- ndig  out  4  digits typed, 0..8.
- full  out  1  ndig == 8.
- A  out  32  last committed A operand.
- B  out  32  last committed B operand.
- ld_a  out  1  one-cycle pulse when A is updated.
- ld_b  out  1  one-cycle pulse when B is updated.
- err  out  1  one-cycle pulse on a rejected key.

## Operation
- key_req passes through a 2-FF synchroniser; req_s is the second stage.
- The synchroniser flops reset to 1, so a key held through reset is never executed.
- FSM states: IDLE, HOLD, WAIT_REL. Reset state is WAIT_REL.
  - IDLE: when req_s=1, execute key_code once (sampled that cycle), load hold-off counter with HOLDOFF-1, go to HOLD.
  - HOLD: decrement the counter. At 0, go to WAIT_REL. key_req is ignored.
  - WAIT_REL: when req_s=0, go to IDLE.
- Key actions:
  - Digit d with ndig<8: entry ← {entry[27:0], d}; ndig+1. A leading 0 counts as a digit.
  - Digit with ndig=8: no change; err pulses.
  - Backspace with ndig>0: entry ← entry>>4; ndig−1.
  - Backspace with ndig=0: no change; err pulses.
  - Clear: entry←0, ndig←0. No err, even if already empty.
  - Commit-A: A←entry, ld_a pulses, entry←0, ndig←0. Commit-B behaves the same on B/ld_b. Committing with ndig=0 loads 0 (legal).
  - Undefined code: no state change; err pulses.
- At most one action per press. ld_a, ld_b and err are mutually exclusive.
- Outputs are registered. full is decoded from the ndig register.

## Timing
- Reset (asserted asynchronously): entry=0, ndig=0, full=0, A=0, B=0, ld_a=ld_b=err=0, counter=0, state=WAIT_REL, sync flops=1.
- After rst_n rises, WAIT_REL exits only after key_req has been sampled low through both sync stages (≥2 clk edges, plus 1 edge for the state change).
- Latency: with key_req rising and meeting setup before clk edge k, the action registers update at edge k+2. ld_a, ld_b and err are high for exactly the cycle after edge k+2.
- Minimum spacing between accepted presses: HOLDOFF cycles in HOLD, then release seen through the synchroniser, then a new press (≥ HOLDOFF+5 cycles press-to-press).
- Glitches on key_req during HOLD or WAIT_REL have no effect.
- A key_req pulse shorter than 2 cycles may be missed; this is not an error.
- Reset mid-HOLD aborts the hold-off. A key still held after reset is not re-executed.
- ld_a/ld_b and the A/B update occur on the same edge, so a consumer sampling on ld_a sees the new A.

## Test plan
- Reset, key_req low 3 cycles, then press digits 1,2,3,4 then commit-A (HOLDOFF=4) → entry 0x1234 after the 4th digit; A=0x00001234; ld_a high exactly 1 cycle; entry=0, ndig=0.
- Press 9 digits F → after 8: entry=0xFFFFFFFF, full=1. 9th press: err pulse 1 cycle, entry unchanged.
- Digits A,B, backspace, backspace, backspace → entry 0xAB, then 0xA, then 0. Third backspace gives err pulse, ndig stays 0.
- Commit-B with ndig=0 while B=0x5 → B=0, ld_b pulse. Code 0x1F → err only, A/B/entry unchanged.
- key_req high, bouncing 0/1 every cycle for 10 cycles during HOLD, then low → exactly one action executed.
- key_req held high across a reset pulse in HOLD → after reset no action until key_req is released and pressed again; outputs all 0.
